// File: rtl/op_f_pkg.sv
// Shared types and sizing for the OP_F sweep sequencer.
// Vector count, index width and dwell-counter width live here so the top and counter agree.
package op_f_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } op_f_state_t;

    localparam int NUM_VEC = 16;
    localparam int VEC_W   = 4;
    localparam int DWELL_W = 8;

endpackage

// File: rtl/dwell_counter.sv
// Modulo counter that runs 0..LAST_VAL while enabled and flags the terminal count.
// A clear wins over the enable, so the owner can park the counter at zero.
module dwell_counter #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] LAST_VAL = '0
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    assign last = (count_q == LAST_VAL);

    // Next count: clear, wrap at terminal count, or step.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            if (last) begin
                count_d = '0;
            end else begin
                count_d = count_q + WIDTH'(1);
            end
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/op_f_sweep_ctrl.sv
// Walks OP_F through all 16 input vectors, holding each for DWELL cycles,
// and captures y/z on the final dwell cycle into two 16-bit truth tables.
module op_f_sweep_ctrl
    import op_f_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic               y,
    input  logic               z,
    output logic               a,
    output logic               b,
    output logic               c,
    output logic               d,
    output logic [VEC_W-1:0]   vec_idx,
    output logic               busy,
    output logic               done,
    output logic               tt_valid,
    output logic [NUM_VEC-1:0] tt_y,
    output logic [NUM_VEC-1:0] tt_z
);

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);
    localparam logic [VEC_W-1:0]   LAST_VEC   = VEC_W'(NUM_VEC - 1);

    op_f_state_t        state_q,    state_d;
    logic [VEC_W-1:0]   vec_idx_q,  vec_idx_d;
    logic               busy_q,     busy_d;
    logic               done_q,     done_d;
    logic               tt_valid_q, tt_valid_d;
    logic [NUM_VEC-1:0] tt_y_q,     tt_y_d;
    logic [NUM_VEC-1:0] tt_z_q,     tt_z_d;

    logic cnt_clr_s;
    logic cnt_en_s;
    logic dwell_last_s;

    // Counter only runs in DRIVE; an abort also parks it so a later sweep starts at phase 0.
    assign cnt_en_s  = (state_q == ST_DRIVE);
    assign cnt_clr_s = (state_q != ST_DRIVE) || abort;

    dwell_counter #(
        .WIDTH    (DWELL_W),
        .LAST_VAL (DWELL_LAST)
    ) u_dwell_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr_s),
        .en   (cnt_en_s),
        .last (dwell_last_s)
    );

    // Next-state, vector stepping and truth-table capture.
    always_comb begin
        state_d    = state_q;
        vec_idx_d  = vec_idx_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        tt_valid_d = tt_valid_q;
        tt_y_d     = tt_y_q;
        tt_z_d     = tt_z_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_DRIVE;
                    vec_idx_d  = '0;
                    busy_d     = 1'b1;
                    tt_valid_d = 1'b0;
                    tt_y_d     = '0;
                    tt_z_d     = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                // Abort outranks the final-cycle sample.
                if (abort) begin
                    state_d   = ST_IDLE;
                    vec_idx_d = '0;
                end else if (dwell_last_s) begin
                    tt_y_d[vec_idx_q] = y;
                    tt_z_d[vec_idx_q] = z;
                    if (vec_idx_q == LAST_VEC) begin
                        state_d    = ST_DONE;
                        done_d     = 1'b1;
                        tt_valid_d = 1'b1;
                    end else begin
                        vec_idx_d = vec_idx_q + VEC_W'(1);
                        busy_d    = 1'b1;
                    end
                end else begin
                    busy_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d   = ST_IDLE;
                vec_idx_d = '0;
            end
            default: begin
                state_d   = ST_IDLE;
                vec_idx_d = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            vec_idx_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tt_valid_q <= 1'b0;
            tt_y_q     <= '0;
            tt_z_q     <= '0;
        end else begin
            state_q    <= state_d;
            vec_idx_q  <= vec_idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            tt_valid_q <= tt_valid_d;
            tt_y_q     <= tt_y_d;
            tt_z_q     <= tt_z_d;
        end
    end

    assign a        = vec_idx_q[3];
    assign b        = vec_idx_q[2];
    assign c        = vec_idx_q[1];
    assign d        = vec_idx_q[0];
    assign vec_idx  = vec_idx_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign tt_valid = tt_valid_q;
    assign tt_y     = tt_y_q;
    assign tt_z     = tt_z_q;

endmodule
